// File: rtl/photodiode_rx_pkg.sv
// Shared types and constants for the photodiode receive deserializer.
// Optional build macro used by this block: PHOTODIODE_RX_MAJORITY_EN.
package photodiode_rx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  localparam int BITS_PER_BYTE = 8;

  function automatic int timer_width(input int timeout_bits, input int clk_per_bit);
    return $clog2(timeout_bits * clk_per_bit + 1);
  endfunction

endpackage

// File: rtl/photodiode_rx_if.sv
// Packet-side output bundle of photodiode_rx; master drives, slave observes.
// data is qualified by the single-cycle new_data strobe; there is no backpressure (ready is implied high).
interface photodiode_rx_if #(
  parameter int PKT_LENGTH = 288
);
  logic [PKT_LENGTH-1:0]     data;
  logic                      new_data;
  logic                      busy;
  logic                      frame_err;
  logic [7:0]                err_count;
  photodiode_rx_pkg::state_t dbg_state;

  modport master (output data, new_data, busy, frame_err, err_count, dbg_state);
  modport slave  (input  data, new_data, busy, frame_err, err_count, dbg_state);
endinterface

// File: rtl/photodiode_rx_byte.sv
// Start/data/stop byte framer working on the synchronized line.
// PHOTODIODE_RX_MAJORITY_EN: each sample becomes a 2-of-3 vote, decided one cycle after mid-bit.
module photodiode_rx_byte
  import photodiode_rx_pkg::*;
#(
  parameter int CLK_PER_BIT = 13540
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_s_i,
  output logic       start_o,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       byte_err_o,
  output state_t     state_o
);

  localparam int BIT_W = $clog2(CLK_PER_BIT + 1);
`ifdef PHOTODIODE_RX_MAJORITY_EN
  localparam int START_LAST = CLK_PER_BIT / 2;
`else
  localparam int START_LAST = CLK_PER_BIT / 2 - 1;
`endif

  state_t           state_q, state_d;
  logic [BIT_W-1:0] tmr_q, tmr_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [1:0]       hist_q;
  logic             sample;

  // hist_q[0] is rx_s one cycle ago (also the falling-edge reference), hist_q[1] two cycles ago.
`ifdef PHOTODIODE_RX_MAJORITY_EN
  assign sample = (rx_s_i & hist_q[0]) | (rx_s_i & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign sample = rx_s_i;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      hist_q  <= 2'b11;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      hist_q  <= {hist_q[0], rx_s_i};
    end
  end

  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q + 1'b1;
    bit_d        = bit_q;
    shift_d      = shift_q;
    start_o      = 1'b0;
    byte_valid_o = 1'b0;
    byte_err_o   = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (hist_q[0] && !rx_s_i) begin
          start_o = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (tmr_q == BIT_W'(START_LAST)) begin
          tmr_d   = '0;
          bit_d   = '0;
          state_d = sample ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tmr_q == BIT_W'(CLK_PER_BIT - 1)) begin
          tmr_d   = '0;
          shift_d = {sample, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (tmr_q == BIT_W'(CLK_PER_BIT - 1)) begin
          tmr_d = '0;
          if (sample) begin
            byte_valid_o = 1'b1;
            state_d      = IDLE;
          end else begin
            byte_err_o = 1'b1;
            state_d    = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        tmr_d = '0;
        if (rx_s_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_data_o = shift_q;
  assign state_o     = state_q;

endmodule

// File: rtl/photodiode_rx.sv
// Photodiode receive deserializer: synchronizer, byte framer, packet assembly, timeout and error count.
// Build option PHOTODIODE_RX_MAJORITY_EN selects majority-vote bit sampling in the byte framer.
module photodiode_rx
  import photodiode_rx_pkg::*;
#(
  parameter int CLK_PER_BIT  = 13540,
  parameter int PKT_LENGTH   = 288,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  photodiode_rx_if.master bus
);

  localparam int N_BYTES = PKT_LENGTH / BITS_PER_BYTE;
  localparam int CNT_W   = $clog2(N_BYTES + 1);
  localparam int TMO_W   = timer_width(TIMEOUT_BITS, CLK_PER_BIT);
  localparam int LIMIT   = TIMEOUT_BITS * CLK_PER_BIT;

  logic [1:0]            sync_q;
  logic                  rx_s;
  logic                  start, byte_valid, byte_err, discard;
  logic [7:0]            byte_data;
  state_t                byte_state;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [PKT_LENGTH-1:0] pkt_q, pkt_d, pkt_next, data_q, data_d;
  logic                  new_data_q, new_data_d, frame_err_q, frame_err_d;
  logic [7:0]            err_q, err_d;

  assign rx_s = sync_q[1];

  photodiode_rx_byte #(.CLK_PER_BIT(CLK_PER_BIT)) u_byte (
    .clk          (clk),
    .rst          (rst),
    .rx_s_i       (rx_s),
    .start_o      (start),
    .byte_valid_o (byte_valid),
    .byte_data_o  (byte_data),
    .byte_err_o   (byte_err),
    .state_o      (byte_state)
  );

  // Synchronizer resets to the idle-high level so reset release never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= 2'b11;
      cnt_q       <= '0;
      tmo_q       <= '0;
      pkt_q       <= '0;
      data_q      <= '0;
      new_data_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_q       <= '0;
    end else begin
      sync_q      <= {sync_q[0], rx};
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      pkt_q       <= pkt_d;
      data_q      <= data_d;
      new_data_q  <= new_data_d;
      frame_err_q <= frame_err_d;
      err_q       <= err_d;
    end
  end

  assign pkt_next = (pkt_q << BITS_PER_BYTE) | PKT_LENGTH'(byte_data);

  always_comb begin
    cnt_d       = cnt_q;
    tmo_d       = '0;
    pkt_d       = pkt_q;
    data_d      = data_q;
    new_data_d  = 1'b0;
    frame_err_d = 1'b0;
    err_d       = err_q;
    discard     = byte_err;
    if (byte_valid) begin
      pkt_d = pkt_next;
      if (cnt_q == CNT_W'(N_BYTES - 1)) begin
        cnt_d      = '0;
        data_d     = pkt_next;
        new_data_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // A start edge keeps tmo_d at zero, so it beats a coincident timeout.
    if (!start && byte_state == IDLE && cnt_q != '0) begin
      if (tmo_q == TMO_W'(LIMIT)) discard = 1'b1;
      else                        tmo_d   = tmo_q + 1'b1;
    end
    if (discard) begin
      cnt_d       = '0;
      frame_err_d = 1'b1;
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
    end
  end

  assign bus.data      = data_q;
  assign bus.new_data  = new_data_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_count = err_q;
  assign bus.busy      = (byte_state != IDLE) || (cnt_q != '0);
  assign bus.dbg_state = byte_state;

endmodule
